countdown_scheduler: RTL
========================

# countdown_scheduler

Shares one prescaled down-counter among four requesters in round-robin order. Each requester asks for a timed interval of its own length, receives exclusive grant while the counter runs, and gets a one-cycle done pulse on expiry. Sits between the application logic and the board LEDs, replacing per-requester countdown counters with one shared timer and exposing the active owner on active-low LEDs.

## Interface
- COUNT_W, 33: counter and load-value width.
- PRESCALE, 3: clk cycles per counter decrement; legal range 1 to 255.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  4  level request per slot i; held high until done[i].
- load_val  in  4*COUNT_W  interval for slot i at [i*COUNT_W +: COUNT_W]; sampled only on grant.
- grant  out  4  one-hot owner of the counter; all zero when idle.
- done  out  4  one-cycle expiry pulse to the owner.
- busy  out  1  high in RUN.
- remaining  out  COUNT_W  current counter value.
- led  out  6  active-low: led[3:0]=~grant, led[4]=~busy, led[5]=~(done!=0).

## Operation
- FSM states IDLE, RUN, DONE. Encoding is free; all outputs are registered.
- IDLE: if any req is set, select the first set bit starting at last_owner+1, wrapping modulo 4. Next cycle: remaining=load_val[sel], psc=0, owner=sel.
  - If the load value is nonzero: next state is RUN, grant[sel]=1.
  - If the load value is zero: next state is DONE, grant stays 0.
- RUN: psc increments each cycle. When psc==PRESCALE-1, psc wraps to 0 and remaining decrements. Remaining never goes below 0.
- RUN to DONE occurs in the same update that brings remaining to 0. Grant clears on that update.
- DONE: done[owner]=1 for exactly one cycle. last_owner=owner. Next state is IDLE.
- Requests from non-owners during RUN/DONE are held pending. An owner's req is not re-evaluated until the next IDLE, where round-robin puts it last.
- Reset values: state=IDLE, grant=0, done=0, busy=0, remaining=0, psc=0, last_owner=3 (slot 0 has first priority), led=6'b111111.
- rst mid-RUN: all outputs return to reset values next cycle and no done is issued.

## Timing
- req seen in IDLE at cycle t; grant and busy are high at t+1.
- With load L>0: first decrement visible at t+PRESCALE+1. remaining reaches 0, and done pulses with grant low, at t+1+L*PRESCALE.
- With L=0: done pulses at t+1.
- State is IDLE one cycle after done. Earliest next grant is two cycles after done, so back-to-back intervals cost L*PRESCALE+2 cycles.
- PRESCALE=1: remaining decrements every RUN cycle.
- A load_val change after grant has no effect.

## Configuration
- COUNTDOWN_SCHED_ABORT_EN defined:
  - Owner deasserting req in RUN aborts the interval. Next cycle: state IDLE, grant=0, remaining=0, no done pulse, last_owner=owner.
  - A req drop in the same cycle remaining reaches 0 still completes with done.
- Undefined: req deassertion in RUN is ignored and the interval always runs to done.

## Test plan
- Reset: hold rst with req=4'hF. Expect grant=0, done=0, busy=0, remaining=0, led=6'b111111 throughout. Release rst, then expect grant=4'b0001 one cycle later.
- Single slot: req[2]=1, load 5, PRESCALE=3, seen at t. Expect grant=4'b0100 at t+1, remaining 4 at t+4, done=4'b0100 at t+16 with grant=0.
- Round-robin: all req high, all loads 2, PRESCALE=3. Expect grants in order 0,1,2,3,0, with done pulses 8 cycles apart.
- Zero load: req[1]=1, load 0. Expect done[1] one cycle after sampling, with grant[1] never high and busy low.
- Mid-run reset: assert rst during RUN with remaining=3. Expect no done and all outputs at reset values next cycle.
- Abort (macro defined): drop req[0] at remaining=7. Expect grant=0 next cycle, no done[0], and a pending req[3] granted the cycle after. Macro undefined: the interval completes with done[0].

Source files
------------

// File: rtl/countdown_scheduler.sv
// countdown_scheduler: one prescaled down-counter shared round-robin by four requesters.
// Build option `COUNTDOWN_SCHED_ABORT_EN: the owner dropping req during RUN aborts its interval.
module countdown_scheduler #(
  parameter int COUNT_W  = 33,
  parameter int PRESCALE = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           req,
  input  logic [4*COUNT_W-1:0] load_val,
  output logic [3:0]           grant,
  output logic [3:0]           done,
  output logic                 busy,
  output logic [COUNT_W-1:0]   remaining,
  output logic [5:0]           led,
  output logic [1:0]           state_dbg
);

  // Handshake: req[i] is a level held until done[i]; grant is the one-hot owner while
  // the counter runs, and done[i] is a single-cycle pulse that ends the owner's interval.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t             state;
  logic [7:0]         psc;
  logic [1:0]         owner;
  logic [1:0]         last_owner;
  logic [1:0]         sel;
  logic [1:0]         idx;
  logic               found;
  logic [COUNT_W-1:0] sel_load;
  logic               tick_end;
  logic               final_dec;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    sel   = 2'd0;
    idx   = 2'd0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_owner + 2'(k);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  assign sel_load  = load_val[int'(sel)*COUNT_W +: COUNT_W];
  assign tick_end  = (psc == 8'(PRESCALE - 1));
  assign final_dec = tick_end && (remaining <= COUNT_W'(1));
  assign led       = {~(|done), ~busy, ~grant};
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 4'b0;
      done       <= 4'b0;
      busy       <= 1'b0;
      remaining  <= '0;
      psc        <= 8'd0;
      owner      <= 2'd0;
      last_owner <= 2'd3;
    end else begin
      done <= 4'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            owner     <= sel;
            remaining <= sel_load;
            psc       <= 8'd0;
            if (sel_load != '0) begin
              state <= RUN;
              grant <= 4'b0001 << sel;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 4'b0001 << sel;
            end
          end
        end
        RUN: begin
          if (tick_end) begin
            psc <= 8'd0;
            if (final_dec) begin
              remaining <= '0;
              state     <= DONE;
              grant     <= 4'b0;
              busy      <= 1'b0;
              done      <= 4'b0001 << owner;
            end else begin
              remaining <= remaining - COUNT_W'(1);
            end
          end else begin
            psc <= psc + 8'd1;
          end
`ifdef COUNTDOWN_SCHED_ABORT_EN
          // A drop on the expiring update still completes normally.
          if (!req[owner] && !final_dec) begin
            state      <= IDLE;
            grant      <= 4'b0;
            busy       <= 1'b0;
            remaining  <= '0;
            psc        <= 8'd0;
            last_owner <= owner;
          end
`endif
        end
        DONE: begin
          last_owner <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
